// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the PC sequencer and instruction memory.
// Latency: none, wires only.
// Backpressure: imem_req is held until imem_ack; memory may stall the fetch indefinitely.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH -> DECODE -> EXEC -> UPDATE loop driving the instruction fetch port.
// Latency: 4 cycles per instruction minimum (ack in first FETCH cycle, exec_done in first EXEC cycle).
// Backpressure: stalls in FETCH until imem_ack and in EXEC until exec_done; PC_SEQ_JR_EN enables pc_src=11 jump-register.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  pc_sequencer_if.master imem,
  output logic [31:0]    ir,
  output logic           ir_valid,
  input  logic           exec_done,
  input  logic [1:0]     pc_src,
  input  logic [31:0]    jr_addr,
  output logic [31:0]    pc,
  output logic           busy,
  output logic           illegal_src
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    UPDATE = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [1:0]  src_q;
  logic [31:0] br_off;
  logic [31:0] next_pc;

`ifdef PC_SEQ_JR_EN
  logic [31:2] jr_q;
  // The two low bits of the register target are always forced to zero.
  logic        unused_jr_lsb;
  assign unused_jr_lsb = ^jr_addr[1:0];
`else
  // Jump-register is not built; the target input is left unconnected internally.
  logic        unused_jr;
  assign unused_jr = ^jr_addr;
`endif

  // Fetch address always tracks the architectural PC.
  assign imem.imem_addr = pc;

  // Branch displacement: sign-extended word offset from the low half of ir.
  assign br_off = {{14{ir[15]}}, ir[15:0], 2'b00};

  // Next-PC select from the source captured when exec_done was seen.
  always_comb begin
    next_pc = pc_plus4;
    case (src_q)
      2'b01:   next_pc = pc_plus4 + br_off;
      2'b10:   next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
`ifdef PC_SEQ_JR_EN
      2'b11:   next_pc = {jr_q, 2'b00};
`endif
      default: next_pc = pc_plus4;
    endcase
  end

  // Sequencer FSM with registered outputs; reset drops the fetch request without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      pc_plus4      <= RESET_PC;
      ir            <= '0;
      ir_valid      <= 1'b0;
      imem.imem_req <= 1'b0;
      busy          <= 1'b0;
      illegal_src   <= 1'b0;
      src_q         <= 2'b00;
`ifdef PC_SEQ_JR_EN
      jr_q          <= '0;
`endif
    end else begin
      ir_valid    <= 1'b0;
      illegal_src <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= FETCH;
            imem.imem_req <= 1'b1;
            busy          <= 1'b1;
          end
        end
        FETCH: begin
          if (imem.imem_ack) begin
            ir            <= imem.imem_data;
            pc_plus4      <= pc + 32'd4;
            imem.imem_req <= 1'b0;
            ir_valid      <= 1'b1;
            state         <= DECODE;
          end
        end
        DECODE: begin
          state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            src_q <= pc_src;
`ifdef PC_SEQ_JR_EN
            jr_q  <= jr_addr[31:2];
`else
            illegal_src <= (pc_src == 2'b11);
`endif
            state <= UPDATE;
          end
        end
        UPDATE: begin
          pc <= next_pc;
          if (start) begin
            state         <= FETCH;
            imem.imem_req <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          imem.imem_req <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed + randomized instruction streams against a PC model.
// A second instance with a high reset PC exercises jumps that keep the upper PC nibble.
// Reset behaviour (asynchronous drop, late ack ignored, restart at reset PC) is checked at the end.
module tb_pc_sequencer;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'h9000_0000;

`ifdef PC_SEQ_JR_EN
  localparam bit JR_EN = 1'b1;
`else
  localparam bit JR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A
  logic        start, exec_done, ir_valid, busy, illegal_src;
  logic [1:0]  pc_src;
  logic [31:0] jr_addr, ir, pc;
  pc_sequencer_if ifa ();

  pc_sequencer #(.RESET_PC(RST_A)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem(ifa.master),
    .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done), .pc_src(pc_src),
    .jr_addr(jr_addr), .pc(pc), .busy(busy), .illegal_src(illegal_src)
  );

  // DUT B (high reset PC)
  logic        b_start, b_exec_done, b_ir_valid, b_busy, b_illegal;
  logic [1:0]  b_pc_src;
  logic [31:0] b_jr_addr, b_ir, b_pc;
  pc_sequencer_if ifb ();

  pc_sequencer #(.RESET_PC(RST_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .imem(ifb.master),
    .ir(b_ir), .ir_valid(b_ir_valid), .exec_done(b_exec_done), .pc_src(b_pc_src),
    .jr_addr(b_jr_addr), .pc(b_pc), .busy(b_busy), .illegal_src(b_illegal)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: next PC straight from the instruction-set rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input logic [1:0] src, input logic [31:0] jr);
    logic [31:0] p4;
    int off;
    p4  = cur + 32'd4;
    off = int'($signed(w[15:0]));
    case (src)
      2'b01:   return p4 + 32'(off * 4);
      2'b10:   return (p4 / 32'h1000_0000) * 32'h1000_0000 + 32'(w[25:0]) * 32'd4;
      2'b11:   return JR_EN ? (jr / 32'd4) * 32'd4 : p4;
      default: return p4;
    endcase
  endfunction

  // Scoreboard queues filled by the stimulus, drained by the monitor.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_ir_q[$];
  int          exp_gap_q[$];
  bit          mon_en = 1'b0;
  int unsigned last_fetch = 0;
  int          ill_seen = 0;
  int          gap_exp;

  // Monitor: compare every accepted fetch, every decode pulse, and count illegal pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ifa.imem_req && ifa.imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_fetch", 32'd1, 32'd0);
        end else begin
          check("fetch_addr", ifa.imem_addr, exp_addr_q.pop_front());
          gap_exp = exp_gap_q.pop_front();
          if (gap_exp != 0) check("fetch_gap", cyc - last_fetch, 32'(gap_exp));
        end
        last_fetch = cyc;
      end
      if (ir_valid) begin
        check("decode_req_low", 32'(ifa.imem_req), 32'd0);
        if (exp_ir_q.size() == 0) check("unexpected_ir_valid", 32'd1, 32'd0);
        else check("ir", ir, exp_ir_q.pop_front());
      end
      if (illegal_src) ill_seen++;
    end
  end

  logic [31:0] mpc;
  int          exp_ill = 0;
  int          prev_w = 0;
  bit          restart = 1'b1;

  task automatic wait_req_a();
    int n = 0;
    while (ifa.imem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (ifa.imem_req !== 1'b1) check("fetch_timeout", 32'(ifa.imem_req), 32'd1);
  endtask

  // One instruction: ack after d cycles, exec_done after w cycles, optional start drop in EXEC.
  task automatic do_instr(input logic [31:0] word, input logic [1:0] src, input logic [31:0] jr,
                          input int d, input int w, input bit drop);
    wait_req_a();
    exp_addr_q.push_back(mpc);
    exp_ir_q.push_back(word);
    exp_gap_q.push_back(restart ? 0 : 4 + prev_w + d);
    repeat (d) begin
      exec_done = 1'($urandom);
      pc_src    = 2'($urandom);
      step();
    end
    ifa.imem_ack  = 1'b1;
    ifa.imem_data = word;
    step();
    ifa.imem_ack  = 1'b0;
    ifa.imem_data = $urandom;
    exec_done     = 1'($urandom);
    step();
    exec_done = 1'b0;
    if (drop) start = 1'b0;
    repeat (w) step();
    exec_done = 1'b1;
    pc_src    = src;
    jr_addr   = jr;
    step();
    exec_done = 1'b0;
    pc_src    = 2'($urandom);
    jr_addr   = $urandom;
    mpc = model_next(mpc, word, src, jr);
    if (src == 2'b11 && !JR_EN) exp_ill++;
    step();
    prev_w  = w;
    restart = drop;
    if (drop) begin
      check("drop_idle_busy", 32'(busy), 32'd0);
      check("drop_idle_req", 32'(ifa.imem_req), 32'd0);
      step();
      step();
      check("drop_hold_busy", 32'(busy), 32'd0);
      start = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    start = 1'b0; exec_done = 1'b0; pc_src = 2'b00; jr_addr = '0;
    ifa.imem_ack = 1'b0; ifa.imem_data = '0;
    b_start = 1'b0; b_exec_done = 1'b0; b_pc_src = 2'b00; b_jr_addr = '0;
    ifb.imem_ack = 1'b0; ifb.imem_data = '0;
    mpc = RST_A;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, RST_A);
    check("rst_ir", ir, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(ifa.imem_req), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_illegal", 32'(illegal_src), 32'd0);
    check("rst_b_pc", b_pc, RST_B);

    rst_n = 1'b1;
    step();
    start  = 1'b1;
    mon_en = 1'b1;

    // Sequential run from reset: 0x0, 0x4, 0x8 at one instruction per 4 cycles.
    do_instr(32'h2000_0001, 2'b00, 32'd0, 0, 0, 1'b0);
    do_instr(32'h2000_0002, 2'b00, 32'd0, 0, 0, 1'b0);
    do_instr(32'h2000_0003, 2'b00, 32'd0, 0, 0, 1'b0);
    // Jump to 0x0040_0010, branch +3 words -> 0x0040_0020.
    do_instr(32'h0810_0004, 2'b10, 32'd0, 0, 0, 1'b0);
    do_instr(32'h1000_0003, 2'b01, 32'd0, 0, 0, 1'b0);
    // Back to 0x0040_0010, branch -2 words -> 0x0040_000C.
    do_instr(32'h0810_0004, 2'b10, 32'd0, 1, 1, 1'b0);
    do_instr(32'h1000_FFFE, 2'b01, 32'd0, 0, 2, 1'b0);
    // Jump to 0, branch -2 words -> 0xFFFF_FFFC, sequential wrap to 0 with start dropped in EXEC.
    do_instr(32'h0800_0000, 2'b10, 32'd0, 2, 0, 1'b0);
    do_instr(32'h1000_FFFE, 2'b01, 32'd0, 0, 0, 1'b0);
    do_instr(32'h0000_0000, 2'b00, 32'd0, 1, 2, 1'b1);
    // Jump-register source with unaligned target.
    do_instr(32'h0000_0000, 2'b11, 32'h0000_1237, 0, 0, 1'b0);
    do_instr(32'h0000_0000, 2'b00, 32'd0, 0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      do_instr($urandom, 2'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0));
    end
    do_instr($urandom, 2'b00, 32'd0, 0, 0, 1'b0);
    step();
    step();
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("ir_q_drained", 32'(exp_ir_q.size()), 32'd0);
    check("illegal_pulses", 32'(ill_seen), 32'(exp_ill));
    mon_en = 1'b0;

    // High reset PC instance: first fetch at 0x9000_0000, jump keeps upper nibble -> 0x9000_0400.
    b_start = 1'b1;
    n = 0;
    while (ifb.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("b_first_addr", ifb.imem_addr, RST_B);
    ifb.imem_ack  = 1'b1;
    ifb.imem_data = 32'h0800_0100;
    step();
    ifb.imem_ack  = 1'b0;
    check("b_ir_valid", 32'(b_ir_valid), 32'd1);
    step();
    b_exec_done = 1'b1;
    b_pc_src    = 2'b10;
    step();
    b_exec_done = 1'b0;
    b_start     = 1'b0;
    check("b_pc_hold_in_update", b_pc, RST_B);
    step();
    check("b_jump_pc", b_pc, 32'h9000_0400);
    check("b_idle_busy", 32'(b_busy), 32'd0);

    // Reset mid-fetch after a 3-cycle ack stall.
    wait_req_a();
    check("pre_rst_req", 32'(ifa.imem_req), 32'd1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_req", 32'(ifa.imem_req), 32'd0);
    check("rst_async_pc", pc, RST_A);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_ir", ir, 32'd0);
    start = 1'b0;
    step();
    rst_n = 1'b1;
    ifa.imem_ack  = 1'b1;
    ifa.imem_data = 32'hDEAD_BEEF;
    step();
    step();
    check("late_ack_busy", 32'(busy), 32'd0);
    check("late_ack_ir", ir, 32'd0);
    check("late_ack_req", 32'(ifa.imem_req), 32'd0);
    ifa.imem_ack = 1'b0;
    start = 1'b1;
    wait_req_a();
    check("post_rst_addr", ifa.imem_addr, RST_A);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
